// File: rtl/bcd_countdown_ctrl_if.sv
// Control/status bundle for the two-digit BCD countdown controller.
// master drives the controls (board/testbench); slave is the controller.
interface bcd_countdown_ctrl_if;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] q_tens;
  logic [3:0] q_ones;
  logic       done;
  logic       alarm;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output load, load_val, start, pause,
    input  q_tens, q_ones, done, alarm, seg, an
  );

  modport slave (
    input  load, load_val, start, pause,
    output q_tens, q_ones, done, alarm, seg, an
  );
endinterface

// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD countdown timer: IDLE/RUN/PAUSE/DONE control, prescaled tick, muxed 7-seg drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module bcd_countdown_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input logic                 clk,
  input logic                 mr,
  bcd_countdown_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    AN_ONES   = 2'b10;
  localparam logic [1:0]    AN_TENS   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_tens, r_ones, w_tens_nxt, w_ones_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [SW-1:0] r_scan, w_scan_nxt;
  logic [1:0]    r_an, w_an_nxt;
  logic [6:0]    r_seg, w_seg_nxt, w_tens_seg;
  logic          r_done, w_done_nxt;
  logic          r_alarm, w_alarm_nxt;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      r_state <= S_IDLE;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_presc <= '0;
      r_scan  <= '0;
      r_an    <= AN_ONES;
      r_seg   <= 7'b1000000;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_presc <= w_presc_nxt;
      r_scan  <= w_scan_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_done  <= w_done_nxt;
      r_alarm <= w_alarm_nxt;
    end
  end

  // Next state, digits and prescaler; load outranks start/pause except in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_presc_nxt = r_presc;
    case (r_state)
      S_IDLE, S_PAUSE, S_DONE: begin
        if (bus.load) begin
          w_state_nxt = S_IDLE;
          w_tens_nxt  = clamp_bcd(bus.load_val[7:4]);
          w_ones_nxt  = clamp_bcd(bus.load_val[3:0]);
          w_presc_nxt = '0;
        end else if (r_state == S_IDLE) begin
          if (bus.start && ((r_tens != 4'd0) || (r_ones != 4'd0))) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end else if (r_state == S_PAUSE) begin
          if (bus.start && !bus.pause) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          w_state_nxt = S_PAUSE;
        end else if (r_presc != PRESC_MAX) begin
          w_presc_nxt = r_presc + PW'(1);
        end else begin
          w_presc_nxt = '0;
          // Tick: borrow from tens when ones is already zero
          if (r_ones != 4'd0) begin
            w_ones_nxt = r_ones - 4'd1;
            if ((r_tens == 4'd0) && (r_ones == 4'd1)) w_state_nxt = S_DONE;
          end else if (r_tens != 4'd0) begin
            w_ones_nxt = 4'd9;
            w_tens_nxt = r_tens - 4'd1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: done/alarm and the digit scan (an/seg switch together on wrap)
  always_comb begin
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_alarm_nxt = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    w_scan_nxt  = r_scan + SW'(1);
    w_an_nxt    = r_an;
    w_seg_nxt   = r_seg;
    w_tens_seg  = seg_enc(r_tens);
`ifdef LEADING_ZERO_BLANK_EN
    if (r_tens == 4'd0) w_tens_seg = 7'b1111111;
`endif
    if (r_scan == SCAN_MAX) begin
      w_scan_nxt = '0;
      if (r_an == AN_ONES) begin
        w_an_nxt  = AN_TENS;
        w_seg_nxt = w_tens_seg;
      end else begin
        w_an_nxt  = AN_ONES;
        w_seg_nxt = seg_enc(r_ones);
      end
    end
  end

  assign bus.q_tens = r_tens;
  assign bus.q_ones = r_ones;
  assign bus.done   = r_done;
  assign bus.alarm  = r_alarm;
  assign bus.an     = r_an;
  assign bus.seg    = r_seg;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Testbench for bcd_countdown_ctrl: directed scenarios plus random traffic against
// an integer-valued reference model (TICK_DIV=4, SCAN_DIV=2).
module tb_bcd_countdown_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned SD = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic mr  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_countdown_ctrl_if bus();

  bcd_countdown_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .mr  (mr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: count value as a plain integer 0..99
  int         m_val, m_mode, m_pre, m_scan;
  logic [1:0] m_an;
  logic [6:0] m_seg;
  logic       m_alarm;

  function automatic logic [6:0] tens_pattern(input int t);
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) return 7'b1111111;
`endif
    return seg_tbl[t];
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic void model_reset();
    m_val = 0; m_mode = M_IDLE; m_pre = 0; m_scan = 0;
    m_an = 2'b10; m_seg = 7'b1000000; m_alarm = 1'b0;
  endfunction

  function automatic void model_step(input logic ld, input logic [7:0] lv,
                                     input logic st, input logic ps);
    int t, o;
    m_alarm = 1'b0;
    if (m_scan == int'(SD) - 1) begin
      m_scan = 0;
      if (m_an == 2'b10) begin
        m_an = 2'b01; m_seg = tens_pattern(m_val / 10);
      end else begin
        m_an = 2'b10; m_seg = seg_tbl[m_val % 10];
      end
    end else begin
      m_scan++;
    end
    if (ld && m_mode != M_RUN) begin
      t = int'(lv[7:4]); o = int'(lv[3:0]);
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      m_val = t * 10 + o; m_mode = M_IDLE; m_pre = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (st && m_val != 0) begin m_mode = M_RUN; m_pre = 0; end
        M_RUN: begin
          if (ps) m_mode = M_PAUSE;
          else if (m_pre == int'(TD) - 1) begin
            m_pre = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin m_mode = M_DONE; m_alarm = 1'b1; end
          end else m_pre++;
        end
        M_PAUSE: if (st && !ps) m_mode = M_RUN;
        default: ;
      endcase
    end
  endfunction

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
    bus.load = ld; bus.load_val = lv; bus.start = st; bus.pause = ps;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(bus.load, bus.load_val, bus.start, bus.pause);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #12;
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h00 || bus.done !== 1'b0 || bus.alarm !== 1'b0 ||
        bus.an !== 2'b10 || bus.seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_initial: q=%h done=%b alarm=%b an=%b seg=%b expected 00 0 0 10 1000000",
               {bus.q_tens, bus.q_ones}, bus.done, bus.alarm, bus.an, bus.seg);
    end
    @(negedge clk); mr = 1'b1;
    drive(1'b1, 8'h37, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step(); step();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h37) begin
      errors++; $display("FAIL reset_pre_run: q=%h expected 37", {bus.q_tens, bus.q_ones});
    end
    #2; mr = 1'b0; #1;
    model_reset();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h00 || bus.done !== 1'b0 || bus.alarm !== 1'b0 ||
        bus.an !== 2'b10 || bus.seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_async: q=%h done=%b alarm=%b an=%b seg=%b expected 00 0 0 10 1000000",
               {bus.q_tens, bus.q_ones}, bus.done, bus.alarm, bus.an, bus.seg);
    end
    @(negedge clk); mr = 1'b1;
  endtask

  task automatic test_countdown();
    int exp_seq[6] = '{24, 23, 22, 21, 20, 19};
    int prev = 25;
    drive(1'b1, 8'h25, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h25) begin
      errors++; $display("FAIL load_25: q=%h expected 25", {bus.q_tens, bus.q_ones});
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    foreach (exp_seq[k]) begin
      repeat (3) step();
      checks++;
      if ({bus.q_tens, bus.q_ones} !== to_bcd(prev)) begin
        errors++; $display("FAIL count_hold_%0d: q=%h expected %h", k, {bus.q_tens, bus.q_ones}, to_bcd(prev));
      end
      step();
      checks++;
      if ({bus.q_tens, bus.q_ones} !== to_bcd(exp_seq[k])) begin
        errors++; $display("FAIL count_step_%0d: q=%h expected %h", k, {bus.q_tens, bus.q_ones}, to_bcd(exp_seq[k]));
      end
      prev = exp_seq[k];
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_done();
    drive(1'b1, 8'h01, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    checks++;
    if (bus.done !== 1'b0 || bus.alarm !== 1'b0 || {bus.q_tens, bus.q_ones} !== 8'h01) begin
      errors++; $display("FAIL done_early: q=%h done=%b alarm=%b expected 01 0 0", {bus.q_tens, bus.q_ones}, bus.done, bus.alarm);
    end
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.alarm !== 1'b1 || {bus.q_tens, bus.q_ones} !== 8'h00) begin
      errors++; $display("FAIL done_entry: q=%h done=%b alarm=%b expected 00 1 1", {bus.q_tens, bus.q_ones}, bus.done, bus.alarm);
    end
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_pulse: done=%b alarm=%b expected 1 0", bus.done, bus.alarm);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.done !== 1'b1 || bus.alarm !== 1'b0 || {bus.q_tens, bus.q_ones} !== 8'h00) begin
      errors++; $display("FAIL done_start: q=%h done=%b alarm=%b expected 00 1 0", {bus.q_tens, bus.q_ones}, bus.done, bus.alarm);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 8'hAF, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.q_tens !== 4'd9 || bus.q_ones !== 4'd9 || bus.done !== 1'b0) begin
      errors++; $display("FAIL load_clamp: q=%h done=%b expected 99 0", {bus.q_tens, bus.q_ones}, bus.done);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b1, 8'h12, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h99) begin
      errors++; $display("FAIL load_in_run: q=%h expected 99", {bus.q_tens, bus.q_ones});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    drive(1'b1, 8'h34, 1'b0, 1'b0); step();
    drive(1'b1, 8'h56, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (6) step();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h56) begin
      errors++; $display("FAIL load_start_same: q=%h expected 56", {bus.q_tens, bus.q_ones});
    end
  endtask

  task automatic test_pause();
    drive(1'b1, 8'h10, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step(); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (11) step();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h10) begin
      errors++; $display("FAIL pause_hold: q=%h expected 10", {bus.q_tens, bus.q_ones});
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h10) begin
      errors++; $display("FAIL resume_early: q=%h expected 10", {bus.q_tens, bus.q_ones});
    end
    step();
    checks++;
    if ({bus.q_tens, bus.q_ones} !== 8'h09) begin
      errors++; $display("FAIL resume_borrow: q=%h expected 09", {bus.q_tens, bus.q_ones});
    end
  endtask

  task automatic test_display();
    logic [1:0] an_hist [8];
    logic [6:0] tens_exp;
`ifdef LEADING_ZERO_BLANK_EN
    tens_exp = 7'b1111111;
`else
    tens_exp = 7'b1000000;
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    drive(1'b1, 8'h05, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      an_hist[i] = bus.an;
      checks++;
      if (!((bus.an === 2'b01 && bus.seg === tens_exp) || (bus.an === 2'b10 && bus.seg === 7'b0010010))) begin
        errors++; $display("FAIL display_slot_%0d: an=%b seg=%b expected 01/%b or 10/0010010", i, bus.an, bus.seg, tens_exp);
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (an_hist[i + 2] !== ~an_hist[i]) begin
        errors++; $display("FAIL display_period_%0d: an=%b expected %b", i, an_hist[i + 2], ~an_hist[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       ld, st, ps;
    logic [7:0] lv;
    for (int c = 0; c < 600; c++) begin
      ld = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 1) == 0) ? {4'h0, 4'($urandom_range(0, 2))} : 8'($urandom);
      st = ($urandom_range(0, 2) == 0);
      ps = ($urandom_range(0, 5) == 0);
      drive(ld, lv, st, ps);
      step();
      checks++;
      if ({bus.q_tens, bus.q_ones} !== to_bcd(m_val) || bus.done !== 1'(m_mode == M_DONE) ||
          bus.alarm !== m_alarm || bus.an !== m_an || bus.seg !== m_seg) begin
        errors++;
        $display("FAIL random_%0d: q=%h done=%b alarm=%b an=%b seg=%b expected q=%h done=%b alarm=%b an=%b seg=%b",
                 c, {bus.q_tens, bus.q_ones}, bus.done, bus.alarm, bus.an, bus.seg,
                 to_bcd(m_val), 1'(m_mode == M_DONE), m_alarm, m_an, m_seg);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_done();
    test_load();
    test_pause();
    test_display();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
